// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: transmitter states,
// common keyboard command bytes and frame/parity helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Number of bits shifted out after the start bit: 8 data, parity, stop.
    localparam int PS2_FRAME_BITS = 10;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Frame as shifted out LSB first: data, then parity, then stop (1).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data pads, plus a
// falling-edge detector on the synchronised clock. Both lines reset to the
// idle (pulled-up) level so no spurious edge is seen after reset.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2c_i,
    input  logic ps2d_i,
    output logic ps2c_o,
    output logic ps2d_o,
    output logic ps2c_fall_o
);

    // Bit 0 carries the clock line, bit 1 the data line.
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic       clk_prev_q;

    // Synchronise both pads and remember the previous synchronised clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            meta_q     <= {ps2d_i, ps2c_i};
            sync_q     <= meta_q;
            clk_prev_q <= sync_q[0];
        end
    end

    assign ps2c_o      = sync_q[0];
    assign ps2d_o      = sync_q[1];
    assign ps2c_fall_o = clk_prev_q & ~sync_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Performs the request-to-send
// handshake (clock inhibit, start bit), shifts out data/parity/stop on the
// device's falling clock edges, checks the device acknowledge and waits for
// the bus to return idle. Pads are driven through open-drain pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    output logic       tx_done,
    output logic       tx_err
);

    // One counter serves both the inhibit interval and the transfer timeout.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    // The counter is 0 in the first cycle of RTS, so the error pulse lands
    // exactly TIMEOUT_CYCLES cycles after RTS entry.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT     = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic                      c_drv_q, c_drv_d;
    logic                      d_drv_q, d_drv_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic clk_sync;
    logic dat_sync;
    logic clk_fall;
    logic accept;
    logic timed_out;

    ps2_line_sync u_line_sync (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .ps2c_i      (ps2c_in),
        .ps2d_i      (ps2d_in),
        .ps2c_o      (clk_sync),
        .ps2d_o      (dat_sync),
        .ps2c_fall_o (clk_fall)
    );

    // Not ready while a completion pulse is showing, so a new request is
    // taken at the earliest one cycle after tx_done/tx_err.
    assign tx_ready  = (state_q == IDLE) && !done_q && !err_q;
    assign accept    = tx_valid && tx_ready;
    assign timed_out = (cnt_q == TIMEOUT_LAST);

    // State register and all datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            c_drv_q   <= 1'b0;
            d_drv_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            c_drv_q   <= c_drv_d;
            d_drv_q   <= d_drv_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: sequencing of inhibit, RTS, bit shifting, ack and idle wait.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        c_drv_d   = c_drv_q;
        d_drv_d   = d_drv_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                c_drv_d = 1'b0;
                d_drv_d = 1'b0;
                if (accept) begin
                    frame_d   = ps2_frame(tx_data);
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    c_drv_d   = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    // Release the clock and present the start bit together.
                    c_drv_d   = 1'b0;
                    d_drv_d   = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = RTS;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RTS, SEND: begin
                if (timed_out) begin
                    c_drv_d = 1'b0;
                    d_drv_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (clk_fall) begin
                        // Open drain: a 1 bit means release the line.
                        d_drv_d   = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[PS2_FRAME_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = (bit_cnt_q == LAST_BIT) ? ACK : SEND;
                    end
                end
            end

            ACK: begin
                if (timed_out) begin
                    c_drv_d = 1'b0;
                    d_drv_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (clk_fall) begin
                        if (!dat_sync) begin
                            state_d = WAIT_IDLE;
                        end else begin
                            d_drv_d = 1'b0;
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end

            WAIT_IDLE: begin
                if (timed_out) begin
                    c_drv_d = 1'b0;
                    d_drv_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (clk_sync && dat_sync) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                c_drv_d = 1'b0;
                d_drv_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign ps2c_drive_low = c_drv_q;
    assign ps2d_drive_low = d_drv_q;
    assign tx_done        = done_q;
    assign tx_err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device-side bus model clocks the frame out,
// samples on rising edges and optionally acks; expected frames and outcomes
// are queued when requests are driven and checked as transfers finish.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 50;
    localparam int TMO  = 20_000;
    localparam int HALF = 100;   // bus half period in CLK cycles (40 us period at 5 MHz)

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       ack;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_drive_low;
    logic       ps2d_drive_low;
    logic       tx_done;
    logic       tx_err;
    logic       bfm_c_low = 1'b0;
    logic       bfm_d_low = 1'b0;

    // Open-drain bus with pull-ups: low if either side pulls.
    assign ps2c_in = ~(ps2c_drive_low | bfm_c_low);
    assign ps2d_in = ~(ps2d_drive_low | bfm_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .ps2c_in        (ps2c_in),
        .ps2d_in        (ps2d_in),
        .ps2c_drive_low (ps2c_drive_low),
        .ps2d_drive_low (ps2d_drive_low),
        .tx_done        (tx_done),
        .tx_err         (tx_err)
    );

    always #100 CLK = ~CLK;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t exp_q[$];

    int   cyc = 0;
    int   inh_run = 0;
    int   last_inh = 0;
    int   c_rise_cyc = 0;
    int   done_cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   bad_pulse = 0;
    logic rts_align = 1'b0;
    logic c_prev = 1'b0;
    logic d_prev = 1'b0;
    logic done_prev = 1'b0;
    logic err_prev = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Observe the DUT outputs mid-cycle: inhibit length, start-bit alignment,
    // completion pulse counts and pulse shape.
    always @(negedge CLK) begin
        if (ps2c_drive_low) inh_run <= inh_run + 1;
        else if (inh_run != 0) begin
            last_inh <= inh_run;
            inh_run  <= 0;
        end
        if (c_prev && !ps2c_drive_low) rts_align <= ps2d_drive_low && !d_prev;
        if (ps2c_drive_low && !c_prev) c_rise_cyc <= cyc;
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (tx_err) err_cnt <= err_cnt + 1;
        if ((tx_done && tx_err) || (tx_done && done_prev) || (tx_err && err_prev))
            bad_pulse <= bad_pulse + 1;
        c_prev    <= ps2c_drive_low;
        d_prev    <= ps2d_drive_low;
        done_prev <= tx_done;
        err_prev  <= tx_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 0;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic ack);
        exp_t e;
        e.data = d;
        e.par  = exp_par(d);
        e.ack  = ack;
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (exp_q.size() != 0);
        chk("sb_nonempty", 32'(ok), 32'd1);
        e = '0;
        if (ok) e = exp_q.pop_front();
    endtask

    task automatic send_cmd(input logic [7:0] d, input logic ack);
        bit rdy;
        rdy = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (tx_ready) begin
                rdy = 1'b1;
                break;
            end
        end
        chk("ready_before", 32'(rdy), 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        push_exp(d, ack);
        @(negedge CLK);
        tx_valid = 1'b0;
    endtask

    // Device model: waits for RTS, then generates 11 bus clocks, sampling
    // data on each rising edge. Returns early after rising edge abort_at.
    task automatic device_rx(input bit do_ack, input int abort_at,
                             output logic [10:0] cap, output bit got_rts);
        cap     = '0;
        got_rts = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge CLK);
            if (ps2c_in && !ps2d_in) begin
                got_rts = 1'b1;
                break;
            end
        end
        if (!got_rts) return;
        cap[0] = ps2d_in;
        repeat (HALF) @(negedge CLK);
        for (int i = 1; i <= 11; i++) begin
            bfm_c_low = 1'b1;
            repeat (HALF) @(negedge CLK);
            bfm_c_low = 1'b0;
            if (i <= 10) cap[i] = ps2d_in;
            if (i == abort_at) return;
            if (i == 10 && do_ack) begin
                repeat (HALF / 5) @(negedge CLK);
                bfm_d_low = 1'b1;
                repeat (HALF - HALF / 5) @(negedge CLK);
            end else if (i == 11) begin
                repeat (HALF / 5) @(negedge CLK);
                bfm_d_low = 1'b0;
            end else begin
                repeat (HALF) @(negedge CLK);
            end
        end
    endtask

    task automatic finish_xfer(input logic [10:0] cap, input bit rts, input int d0, input int e0);
        exp_t e;
        bit   ok;
        bit   seen;
        pop_exp(e, ok);
        if (!ok) return;
        $display("xfer 0x%02h: start=%0d data=0x%02h par=%0d stop=%0d ack=%0d",
                 e.data, cap[0], cap[8:1], cap[9], cap[10], e.ack);
        chk("rts_seen", 32'(rts), 32'd1);
        chk("inhibit_len", 32'(last_inh), 32'(INH));
        chk("start_align", 32'(rts_align), 32'd1);
        chk("start_bit", 32'(cap[0]), 32'd0);
        chk("data_bits", 32'(cap[8:1]), 32'(e.data));
        chk("parity_bit", 32'(cap[9]), 32'(e.par));
        chk("stop_bit", 32'(cap[10]), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge CLK);
            if (done_cnt != d0 || err_cnt != e0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("outcome_seen", 32'(seen), 32'd1);
        @(negedge CLK);
        chk("done_count", 32'(done_cnt - d0), 32'(e.ack));
        chk("err_count", 32'(err_cnt - e0), 32'(!e.ack));
        chk("ready_after", 32'(tx_ready), 32'd1);
        chk("ps2c_released", 32'(ps2c_drive_low), 32'd0);
        chk("ps2d_released", 32'(ps2d_drive_low), 32'd0);
    endtask

    task automatic run_xfer(input logic [7:0] d, input logic ack);
        logic [10:0] cap;
        bit          rts;
        int          d0;
        int          e0;
        send_cmd(d, ack);
        d0 = done_cnt;
        e0 = err_cnt;
        device_rx(ack, 0, cap, rts);
        finish_xfer(cap, rts, d0, e0);
    endtask

    initial begin
        #15_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] cap;
        bit          rts;
        bit          found;
        exp_t        e;
        bit          ok;
        int          d0;
        int          e0;
        int          rts_cyc;

        // Reset values
        #5 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_ps2c", 32'(ps2c_drive_low), 32'd0);
        chk("rst_ps2d", 32'(ps2d_drive_low), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_err", 32'(tx_err), 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Set LEDs and parity corner cases, all acked
        run_xfer(PS2_CMD_SET_LEDS, 1'b1);
        run_xfer(8'h00, 1'b1);
        run_xfer(8'h01, 1'b1);
        run_xfer(PS2_CMD_RESET, 1'b1);

        // Device never acks
        run_xfer(8'h5A, 1'b0);

        // Device never clocks: timeout measured from RTS entry
        send_cmd(8'h55, 1'b0);
        d0 = done_cnt;
        e0 = err_cnt;
        found = 1'b0;
        rts_cyc = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge CLK);
            if (ps2d_drive_low) begin
                found = 1'b1;
                break;
            end
        end
        rts_cyc = cyc;
        chk("to_rts_seen", 32'(found), 32'd1);
        found = 1'b0;
        for (int k = 0; k < TMO + 500; k++) begin
            @(negedge CLK);
            if (tx_err) begin
                found = 1'b1;
                break;
            end
        end
        chk("to_err_seen", 32'(found), 32'd1);
        chk("to_latency", 32'(cyc - rts_cyc), 32'(TMO));
        chk("to_ps2c_released", 32'(ps2c_drive_low), 32'd0);
        chk("to_ps2d_released", 32'(ps2d_drive_low), 32'd0);
        @(negedge CLK);
        chk("to_ready_after", 32'(tx_ready), 32'd1);
        chk("to_done_count", 32'(done_cnt - d0), 32'd0);
        pop_exp(e, ok);
        $display("xfer 0x%02h: timeout err_pulses=%0d", e.data, err_cnt - e0);

        // Reset after bit 4 while the data line is being pulled low
        send_cmd(8'h30, 1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        device_rx(1'b1, 4, cap, rts);
        #37 RST_N = 1'b0;
        #1;
        chk("mid_rst_ps2c", 32'(ps2c_drive_low), 32'd0);
        chk("mid_rst_ps2d", 32'(ps2d_drive_low), 32'd0);
        chk("mid_rst_ready", 32'(tx_ready), 32'd1);
        pop_exp(e, ok);
        chk("mid_rst_start", 32'(cap[0]), 32'd0);
        chk("mid_rst_low_nibble", 32'(cap[4:1]), 32'(e.data[3:0]));
        $display("xfer 0x%02h: reset after bit 4, low nibble=0x%0h", e.data, cap[4:1]);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
        run_xfer(PS2_CMD_ECHO, 1'b1);

        // Request held with data changed mid-transfer
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (tx_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk("busy_ready", 32'(found), 32'd1);
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        push_exp(8'h12, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (ps2c_drive_low) begin
                found = 1'b1;
                break;
            end
        end
        chk("busy_accept", 32'(found), 32'd1);
        tx_data = 8'h34;
        push_exp(8'h34, 1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        device_rx(1'b1, 0, cap, rts);
        finish_xfer(cap, rts, d0, e0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (ps2c_drive_low) begin
                found = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        chk("busy_second_start", 32'(found), 32'd1);
        chk("busy_gap", 32'(c_rise_cyc - done_cyc), 32'd2);
        @(negedge CLK);
        tx_valid = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        device_rx(1'b1, 0, cap, rts);
        finish_xfer(cap, rts, d0, e0);

        repeat (5) @(negedge CLK);
        chk("pulse_shape", 32'(bad_pulse), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), over the same two-wire bus the keyboard scan-code receiver listens on. It implements the full request-to-send sequence, odd parity, and acknowledge check, and drives the bus through open-drain enables. It sits between the piano control logic and the PS/2 pads.

## Interface
Parameters:
- INHIBIT_CYCLES, default 6_000: number of CLK cycles the host holds the PS/2 clock low (120 µs at 50 MHz).
- TIMEOUT_CYCLES, default 1_000_000: maximum CLK cycles from releasing the clock to the end of the ack phase (20 ms at 50 MHz).

Ports:
- CLK  in  1  system clock; the only clock in the block.
- RST_N  in  1  asynchronous, active-low reset.
- tx_valid  in  1  command request.
- tx_data  in  8  command byte.
- tx_ready  out  1  block is idle and accepts a request.
- ps2c_in  in  1  PS/2 clock pad, raw and asynchronous.
- ps2d_in  in  1  PS/2 data pad, raw and asynchronous.
- ps2c_drive_low  out  1  1 pulls the clock pad to 0; 0 releases it (pull-up).
- ps2d_drive_low  out  1  1 pulls the data pad to 0; 0 releases it.
- tx_done  out  1  one-cycle pulse: byte sent and device acked.
- tx_err  out  1  one-cycle pulse: missing ack or timeout.

## Operation
- **Input synchronisation:** ps2c_in and ps2d_in each pass through a 2-flop synchroniser that resets to 1. A falling edge (fall) is detected when the previous synchronised clock is 1 and the current one is 0.
- **Accept:** the block accepts a request when tx_valid && tx_ready. It then latches a 10-bit frame {stop=1, parity=~^tx_data, tx_data}, shifted out LSB first.
- **State machine:**
  - IDLE: tx_ready=1, both pad drives 0. On accept → INHIBIT, counter cleared.
  - INHIBIT: ps2c_drive_low=1 for exactly INHIBIT_CYCLES cycles → RTS.
  - RTS: ps2d_drive_low=1 (start bit), ps2c_drive_low=0, bit counter=0, timeout counter starts.
  - RTS/SEND on each fall: drive the next frame bit (ps2d_drive_low = ~bit), increment the bit counter. After the 10th bit (stop, data released) → ACK.
  - ACK: on the next fall, sample the synchronised data line. 0 → WAIT_IDLE; 1 → tx_err pulse → IDLE.
  - WAIT_IDLE: wait until the synchronised clock and data are both 1 → tx_done pulse → IDLE.
- **Timeout:** in RTS, SEND, ACK or WAIT_IDLE, when the counter reaches TIMEOUT_CYCLES the block releases both drives, pulses tx_err and returns to IDLE. The timeout wins over any fall in that same cycle.
- **tx_valid while busy:** ignored, and tx_data is not re-latched.
- **Reset:** asserting RST_N mid-transfer immediately releases both pads, clears the frame, and forces IDLE. Reset values: tx_ready=1, ps2c_drive_low=0, ps2d_drive_low=0, tx_done=0, tx_err=0.

## Timing
- **Clock inhibit:** ps2c_drive_low rises on the CLK edge after accept and stays high for exactly INHIBIT_CYCLES cycles.
- **Start bit:** ps2d_drive_low rises in the same cycle ps2c_drive_low falls.
- **Data updates:** each data change is registered on the cycle after the fall is detected, 3 CLK cycles after the pad edge. This is well inside the device's clock-low half period (≥30 µs).
- **Completion pulses:** tx_done and tx_err are registered, exactly 1 cycle wide, and mutually exclusive. tx_ready returns to 1 on the cycle after the pulse.
- **Back-to-back:** the earliest next accept is 1 cycle after the tx_done or tx_err pulse.

## Structure
- **Package ps2_pkg:**
  - state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE)
  - command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ECHO=8'hEE, PS2_CMD_RESET=8'hFF
  - odd-parity function
- **Sub-module ps2_line_sync:** 2-flop synchroniser plus falling-edge detect. It is shared with the scan-code receiver path.
- **Target size:** 120–400 lines of RTL in total.

## Test plan
All scenarios run with INHIBIT_CYCLES=50 and TIMEOUT_CYCLES=20_000. The device BFM generates a 40 µs-period bus clock and samples data on the rising edge.

- **Set LEDs:** tx_data=0xED → inhibit lasts 50 cycles; BFM captures start=0, data=0xED, parity=1, stop=1; BFM acks → single tx_done, tx_err never asserted.
- **Parity cases:** 0x00 → parity 1; 0x01 → parity 0; 0xFF → parity 1. Each is captured correctly and ends with tx_done.
- **No ack:** BFM leaves data high on the 11th clock → tx_err pulse, both drives 0, tx_ready=1.
- **Timeout:** BFM never clocks after RTS → tx_err exactly TIMEOUT_CYCLES cycles after RTS entry; pads released.
- **Reset mid-transfer:** RST_N low after bit 4 → pads released asynchronously, tx_ready=1; a following 0xEE transfer completes with tx_done.
- **Busy request:** tx_valid held with tx_data changed mid-transfer → the original byte is transmitted, and a second transfer starts only after tx_done.
